// File: rtl/inscache_if.sv
// Fetch-side and memory-controller-side signals of the instruction cache.
// The slave view is the cache itself; the master view is its environment.
interface inscache_if;
    logic [31:0] pc;
    logic        ask_for;
    logic        give_you;
    logic [31:0] g_ins;
    logic        mc_req;
    logic [31:0] mc_addr;
    logic        mc_done;
    logic [31:0] mc_data;

    modport slave (
        input  pc, ask_for, mc_done, mc_data,
        output give_you, g_ins, mc_req, mc_addr
    );

    modport master (
        output pc, ask_for, mc_done, mc_data,
        input  give_you, g_ins, mc_req, mc_addr
    );
endinterface

// File: rtl/inscache.sv
// Direct-mapped read-only instruction cache with 16-byte lines refilled word by word,
// combinational hit path, and assembly of 32-bit instructions straddling two lines.
module inscache #(
    parameter int IDX_W = 4
) (
    input  logic     clk_in,
    input  logic     rst_in,
    input  logic     rdy_in,
    inscache_if.slave bus
);
    localparam int LINES = 1 << IDX_W;
    localparam int TAG_W = 28 - IDX_W;

    typedef enum logic {IDLE, REFILL} state_t;

    state_t           state_reg, state_next;
    logic [1:0]       cnt_reg, cnt_next;
    logic [27:0]      base_reg, base_next;
    logic [LINES-1:0] valid_reg, valid_next;
    logic             fill_we;

    logic [31:0]      data_mem [LINES][4];
    logic [TAG_W-1:0] tag_mem  [LINES];

    logic [2:0]       offset;
    logic [27:0]      line_a, line_b, miss_line;
    logic [IDX_W-1:0] idx_a, idx_b, base_idx;
    logic             hit_a, hit_b, hit, compressed;
    logic [127:0]     line_a_data;
    logic [143:0]     window;
    logic [15:0]      hw7;
    logic [31:0]      ins;
    logic             unused_pc0;

    assign unused_pc0 = bus.pc[0];

    // Line B is the successor line; the 28-bit add wraps modulo 2^32 bytes.
    assign offset   = bus.pc[3:1];
    assign line_a   = bus.pc[31:4];
    assign line_b   = line_a + 28'd1;
    assign idx_a    = line_a[IDX_W-1:0];
    assign idx_b    = line_b[IDX_W-1:0];
    assign base_idx = base_reg[IDX_W-1:0];

    assign hit_a = valid_reg[idx_a] && (tag_mem[idx_a] == line_a[27:IDX_W]);
    assign hit_b = valid_reg[idx_b] && (tag_mem[idx_b] == line_b[27:IDX_W]);

    assign line_a_data = {data_mem[idx_a][3], data_mem[idx_a][2],
                          data_mem[idx_a][1], data_mem[idx_a][0]};
    assign hw7         = line_a_data[127:112];
    assign compressed  = (hw7[1:0] != 2'b11);
    // Appending B.hw0 lets offset 7 use the same 32-bit window select as the rest.
    assign window      = {data_mem[idx_b][0][15:0], line_a_data};

    always_comb begin
        ins = window[{offset, 4'b0000} +: 32];
        if (offset == 3'd7 && compressed) begin
            ins = {16'h0000, hw7};
        end
    end

    assign hit       = (offset != 3'd7) ? hit_a : (hit_a && (compressed || hit_b));
    assign miss_line = hit_a ? line_b : line_a;

    assign bus.give_you = rdy_in && bus.ask_for && hit && (state_reg == IDLE);
    assign bus.g_ins    = bus.give_you ? ins : 32'h0;
    assign bus.mc_req   = (state_reg == REFILL);
    assign bus.mc_addr  = {base_reg, cnt_reg, 2'b00};

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        base_next  = base_reg;
        valid_next = valid_reg;
        fill_we    = 1'b0;
        if (rdy_in) begin
            case (state_reg)
                IDLE: begin
                    if (bus.ask_for && !hit) begin
                        base_next                          = miss_line;
                        cnt_next                           = 2'd0;
                        valid_next[miss_line[IDX_W-1:0]]   = 1'b0;
                        state_next                         = REFILL;
                    end
                end
                REFILL: begin
                    if (bus.mc_done) begin
                        fill_we  = 1'b1;
                        cnt_next = cnt_reg + 2'd1;
                        if (cnt_reg == 2'd3) begin
                            valid_next[base_idx] = 1'b1;
                            state_next           = IDLE;
                        end
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_reg <= IDLE;
            cnt_reg   <= 2'd0;
            base_reg  <= 28'd0;
            valid_reg <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            base_reg  <= base_next;
            valid_reg <= valid_next;
        end
    end

    // Data and tags carry no reset; valid bits alone decide what is usable.
    always_ff @(posedge clk_in) begin
        if (fill_we) begin
            data_mem[base_idx][cnt_reg] <= bus.mc_data;
            if (cnt_reg == 2'd3) begin
                tag_mem[base_idx] <= base_reg[27:IDX_W];
            end
        end
    end
endmodule

// File: tb/tb_inscache.sv
// Directed bench for inscache: a memory responder checks request addresses and a
// monitor scores every give_you against the queued instruction and cycle.
module tb_inscache;
    logic clk_in = 1'b0;
    logic rst_in;
    logic rdy_in;
    logic junk_en;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

    logic [31:0] mem [256];
    logic [31:0] addr_q [$];
    logic [31:0] exp_q [$];
    int          cyc_q [$];

    inscache_if bus ();

    inscache #(.IDX_W(4)) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .rdy_in (rdy_in),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) cyc <= cyc + 1;

    // Memory controller model: answers every request one word per cycle.
    always @(negedge clk_in) begin
        if (!rst_in) begin
            bus.mc_done = 1'b0;
        end else if (bus.mc_req && !rdy_in && junk_en) begin
            bus.mc_done = 1'b1;
            bus.mc_data = 32'hDEAD_BEEF;
        end else if (bus.mc_req && rdy_in) begin
            vectors++;
            if (addr_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_req: got mc_addr %h, expected no request", bus.mc_addr);
            end else begin
                logic [31:0] ea;
                ea = addr_q.pop_front();
                if (bus.mc_addr !== ea) begin
                    miscompares++;
                    $display("FAIL mc_addr: got %h expected %h", bus.mc_addr, ea);
                end else begin
                    $display("req  addr=%h ok", bus.mc_addr);
                end
            end
            bus.mc_done = 1'b1;
            bus.mc_data = mem[bus.mc_addr[9:2]];
        end else begin
            bus.mc_done = 1'b0;
        end
    end

    // Scoreboard monitor: one pop per cycle in which the cache presents an instruction.
    always @(negedge clk_in) begin
        if (bus.give_you) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_give: got g_ins %h, expected give_you=0", bus.g_ins);
            end else begin
                logic [31:0] e;
                int          c;
                e = exp_q.pop_front();
                c = cyc_q.pop_front();
                if (bus.g_ins !== e) begin
                    miscompares++;
                    $display("FAIL g_ins: pc=%h got %h expected %h", bus.pc, bus.g_ins, e);
                end else begin
                    $display("hit  pc=%h g_ins=%h cycle=%0d", bus.pc, bus.g_ins, cyc);
                end
                if (c >= 0) begin
                    vectors++;
                    if (cyc != c) begin
                        miscompares++;
                        $display("FAIL hit_cycle: pc=%h got cycle %0d expected %0d", bus.pc, cyc, c);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("chk  %s=%h ok", name, act);
        end
    endtask

    task automatic push_line(input logic [31:0] base);
        for (int i = 0; i < 4; i++) addr_q.push_back(base + 32'(4 * i));
    endtask

    task automatic do_reset();
        bus.ask_for = 1'b0;
        rst_in = 1'b0;
        addr_q.delete();
        exp_q.delete();
        cyc_q.delete();
        repeat (2) @(posedge clk_in);
        #3 rst_in = 1'b1;
        @(posedge clk_in);
        #1;
    endtask

    // Called at posedge+1: request pc, wait (bounded) for the monitor's cycle, then release.
    task automatic fetch(input logic [31:0] a, input logic [31:0] exp, input int lat);
        bit seen;
        seen = 1'b0;
        bus.pc      = a;
        bus.ask_for = 1'b1;
        exp_q.push_back(exp);
        cyc_q.push_back(cyc + lat);
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk_in);
            if (bus.give_you) seen = 1'b1;
        end
        if (!seen) begin
            vectors++;
            miscompares++;
            $display("FAIL timeout: pc=%h got no give_you, expected %h", a, exp);
            exp_q.delete();
            cyc_q.delete();
        end
        @(posedge clk_in);
        #1 bus.ask_for = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + 32'(i);
        bus.pc      = 32'h0;
        bus.ask_for = 1'b0;
        bus.mc_done = 1'b0;
        bus.mc_data = 32'h0;
        rdy_in      = 1'b1;
        junk_en     = 1'b0;
        rst_in      = 1'b0;

        repeat (2) @(posedge clk_in);
        #1;
        chk("rst_give_you", {31'b0, bus.give_you}, 32'h0);
        chk("rst_g_ins", bus.g_ins, 32'h0);
        chk("rst_mc_req", {31'b0, bus.mc_req}, 32'h0);
        chk("rst_mc_addr", bus.mc_addr, 32'h0);
        #2 rst_in = 1'b1;
        @(posedge clk_in);
        #1;

        // Cold miss, then a hit spanning words 1 and 2.
        push_line(32'h00);
        fetch(32'h00, 32'h1000_0000, 5);
        fetch(32'h06, 32'h0002_1000, 0);
        chk("t1_addr_left", 32'(addr_q.size()), 32'h0);

        // Straddle with 32-bit hw7 = 0x0003: both lines refilled serially.
        do_reset();
        mem[7] = 32'h0003_0000;
        push_line(32'h10);
        push_line(32'h20);
        fetch(32'h1E, 32'h0008_0003, 10);
        chk("t2_addr_left", 32'(addr_q.size()), 32'h0);

        // Straddle with compressed hw7: only line 0x10 is fetched.
        do_reset();
        mem[7] = 32'h4501_0000;
        push_line(32'h10);
        fetch(32'h1E, 32'h0000_4501, 5);
        repeat (3) @(posedge clk_in);
        #1 chk("t3_addr_left", 32'(addr_q.size()), 32'h0);
        chk("t3_mc_req", {31'b0, bus.mc_req}, 32'h0);

        // Conflict eviction on index 0.
        mem[7] = 32'h1000_0007;
        push_line(32'h000);
        fetch(32'h000, 32'h1000_0000, 5);
        push_line(32'h100);
        fetch(32'h100, 32'h1000_0040, 5);
        push_line(32'h000);
        fetch(32'h000, 32'h1000_0000, 5);

        // Redirect after two words, then a 3-cycle stall with junk mc_done pulses.
        bus.pc      = 32'h80;
        bus.ask_for = 1'b1;
        push_line(32'h80);
        repeat (3) @(posedge clk_in);
        #1;
        bus.pc      = 32'h300;
        bus.ask_for = 1'b0;
        rdy_in      = 1'b0;
        junk_en     = 1'b1;
        chk("t5_stall_addr", bus.mc_addr, 32'h88);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_in);
            #1;
            chk("t5_stall_addr", bus.mc_addr, 32'h88);
            chk("t5_stall_req", {31'b0, bus.mc_req}, 32'h1);
        end
        rdy_in  = 1'b1;
        junk_en = 1'b0;
        repeat (4) @(posedge clk_in);
        #1;
        chk("t5_addr_left", 32'(addr_q.size()), 32'h0);
        fetch(32'h8A, 32'h0023_1000, 0);

        // Straddle across the top of the address space into line 0.
        do_reset();
        mem[255] = 32'h0007_0000;
        push_line(32'hFFFF_FFF0);
        push_line(32'h0000_0000);
        fetch(32'hFFFF_FFFE, 32'h0000_0007, 10);
        chk("t6_addr_left", 32'(addr_q.size()), 32'h0);

        // Asynchronous reset in the middle of a refill.
        fetch(32'h00, 32'h1000_0000, 0);
        bus.pc      = 32'h40;
        bus.ask_for = 1'b1;
        push_line(32'h40);
        repeat (2) @(posedge clk_in);
        #3 rst_in = 1'b0;
        #1;
        chk("t7_rst_mc_req", {31'b0, bus.mc_req}, 32'h0);
        chk("t7_rst_give_you", {31'b0, bus.give_you}, 32'h0);
        chk("t7_rst_mc_addr", bus.mc_addr, 32'h0);
        addr_q.delete();
        bus.ask_for = 1'b0;
        @(posedge clk_in);
        #3 rst_in = 1'b1;
        @(posedge clk_in);
        #1;
        push_line(32'h00);
        fetch(32'h00, 32'h1000_0000, 5);

        repeat (3) @(posedge clk_in);
        #1;
        chk("end_addr_left", 32'(addr_q.size()), 32'h0);
        chk("end_exp_left", 32'(exp_q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected end within 200000 time units");
        $fatal(1, "watchdog expired");
    end
endmodule
